// File: rtl/axo_mem_dma_pkg.sv
// Shared types and error codes for the axo_mem DMA copy engine.
// The AXO_MEM_* codes are what responders return on rdata with error=1.
package axo_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } axo_dma_state_t;

    localparam logic [31:0] AXO_MEM_DECERR   = 32'h0000_0001;
    localparam logic [31:0] AXO_MEM_READONLY = 32'h0000_0002;
    localparam logic [31:0] AXO_MEM_MISALIGN = 32'h0000_0003;
    localparam logic [31:0] AXO_DMA_EALIGN   = 32'h0000_0010;

endpackage

// File: rtl/axo_mem_dma_if.sv
// axo_mem_bus: single-outstanding word bus; an access completes in the
// first cycle the responder raises ready while re or we is held.
interface axo_mem_bus #(
    parameter int alen = 32,
    parameter int dlen = 32
);
    logic            re;
    logic            we;
    logic [1:0]      asize;
    logic [alen-1:0] addr;
    logic [dlen-1:0] wdata;
    logic [dlen-1:0] rdata;
    logic            ready;
    logic            error;

    modport master (output re, we, asize, addr, wdata, input rdata, ready, error);
    modport slave  (input re, we, asize, addr, wdata, output rdata, ready, error);
endinterface

// File: rtl/axo_mem_dma.sv
// Word-granular DMA copy engine on axo_mem_bus: read SRC word, write DST word, LEN times.
// Optional macro AXO_DMA_FILL_EN adds a fill port that writes the src value to every DST word.
module axo_mem_dma
    import axo_dma_pkg::*;
#(
    parameter int alen    = 32,
    parameter int dlen    = 32,
    parameter int lenbits = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [alen-1:0]    src,
    input  logic [alen-1:0]    dst,
    input  logic [lenbits-1:0] len,
`ifdef AXO_DMA_FILL_EN
    input  logic               fill,
`endif
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [31:0]        err_code,
    axo_mem_bus.master         bus
);

    axo_dma_state_t     state, state_n;
    logic               re_q, re_n, we_q, we_n;
    logic [alen-1:0]    addr_q, addr_n;
    logic [dlen-1:0]    wdata_q, wdata_n;
    logic               busy_n, done_n, err_n;
    logic [31:0]        err_code_n;
    logic [alen-1:0]    cur_src, src_n, cur_dst, dst_n;
    logic [lenbits-1:0] rem, rem_n;
    logic               fill_q, fill_n, fill_in, misaligned;

`ifdef AXO_DMA_FILL_EN
    assign fill_in = fill;
`else
    assign fill_in = 1'b0;
`endif

    // In fill mode the src value is data, not an address, so only dst must be aligned.
    assign misaligned = (dst[1:0] != 2'b00) || (!fill_in && (src[1:0] != 2'b00));

    assign bus.re    = re_q;
    assign bus.we    = we_q;
    assign bus.asize = 2'd2;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
        end else begin
            state    <= state_n;
            re_q     <= re_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
            err_code <= err_code_n;
        end
    end

    always_ff @(posedge clk) begin
        cur_src <= src_n;
        cur_dst <= dst_n;
        rem     <= rem_n;
        fill_q  <= fill_n;
    end

    always_comb begin
        state_n    = state;
        re_n       = re_q;
        we_n       = we_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        busy_n     = busy;
        done_n     = 1'b0;
        err_n      = err;
        err_code_n = err_code;
        src_n      = cur_src;
        dst_n      = cur_dst;
        rem_n      = rem;
        fill_n     = fill_q;
        unique case (state)
            IDLE: if (start) begin
                src_n      = src;
                dst_n      = dst;
                rem_n      = len;
                fill_n     = fill_in;
                err_n      = 1'b0;
                err_code_n = '0;
                if (len == '0) begin
                    state_n = FIN;
                    done_n  = 1'b1;
                end else if (misaligned) begin
                    err_n      = 1'b1;
                    err_code_n = AXO_DMA_EALIGN;
                    state_n    = FIN;
                    done_n     = 1'b1;
                end else if (fill_in) begin
                    state_n = WR;
                    we_n    = 1'b1;
                    addr_n  = dst;
                    wdata_n = dlen'(src);
                    busy_n  = 1'b1;
                end else begin
                    state_n = RD;
                    re_n    = 1'b1;
                    addr_n  = src;
                    busy_n  = 1'b1;
                end
            end
            RD: if (bus.ready) begin
                re_n = 1'b0;
                if (bus.error) begin
                    err_n      = 1'b1;
                    err_code_n = 32'(bus.rdata);
                    busy_n     = 1'b0;
                    done_n     = 1'b1;
                    state_n    = FIN;
                end else begin
                    wdata_n = bus.rdata;
                    we_n    = 1'b1;
                    addr_n  = cur_dst;
                    state_n = WR;
                end
            end
            WR: if (bus.ready) begin
                we_n = 1'b0;
                if (bus.error) begin
                    err_n      = 1'b1;
                    err_code_n = 32'(bus.rdata);
                    busy_n     = 1'b0;
                    done_n     = 1'b1;
                    state_n    = FIN;
                end else begin
                    src_n = cur_src + alen'(4);
                    dst_n = cur_dst + alen'(4);
                    rem_n = rem - lenbits'(1);
                    // Next access is issued back-to-back so a zero-wait responder sees no idle cycle.
                    if (rem == lenbits'(1)) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = FIN;
                    end else if (fill_q) begin
                        we_n   = 1'b1;
                        addr_n = cur_dst + alen'(4);
                    end else begin
                        re_n    = 1'b1;
                        addr_n  = cur_src + alen'(4);
                        state_n = RD;
                    end
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axo_mem_dma.sv
// Directed bench for axo_mem_dma against a 256-word RAM responder with
// programmable wait states and write-error injection.
module tb_axo_mem_dma;
    import axo_dma_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src_i, dst_i;
    logic [15:0] len_i;
    logic        busy, done, err;
    logic [31:0] err_code;
`ifdef AXO_DMA_FILL_EN
    logic        fill_i;
`endif

    axo_mem_bus #(.alen(32), .dlen(32)) bus ();

    axo_mem_dma #(.alen(32), .dlen(32), .lenbits(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src      (src_i),
        .dst      (dst_i),
        .len      (len_i),
`ifdef AXO_DMA_FILL_EN
        .fill     (fill_i),
`endif
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder model
    logic [31:0] mem [256];
    logic [31:0] snap [256];
    int ws, err_wr, wr_base, wcnt, rd_cnt, wr_cnt;

    function automatic logic [31:0] init_word(input int i);
        if (i >= 64 && i < 68) return 32'(i - 63);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    always_comb begin
        bus.ready = (bus.re || bus.we) && (wcnt == ws);
        bus.error = bus.we && bus.ready && ((wr_cnt - wr_base + 1) == err_wr);
        bus.rdata = bus.error ? AXO_MEM_READONLY : mem[bus.addr[9:2]];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt   <= 0;
            rd_cnt <= 0;
            wr_cnt <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (bus.re || bus.we) begin
            if (bus.ready) begin
                wcnt <= 0;
                if (bus.re) rd_cnt <= rd_cnt + 1;
                else if (!bus.error) begin
                    wr_cnt <= wr_cnt + 1;
                    mem[bus.addr[9:2]] <= bus.wdata;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // Bus protocol monitor: no simultaneous re/we, request held stable while stalled
    int both_viol, stab_viol;
    logic pend, p_re, p_we;
    logic [31:0] p_addr, p_wdata;
    initial begin both_viol = 0; stab_viol = 0; pend = 1'b0; end

    always @(negedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (bus.re && bus.we) both_viol <= both_viol + 1;
            if (pend && (bus.re !== p_re || bus.we !== p_we || bus.addr !== p_addr || bus.wdata !== p_wdata))
                stab_viol <= stab_viol + 1;
            if ((bus.re || bus.we) && !bus.ready) begin
                pend <= 1'b1; p_re <= bus.re; p_we <= bus.we; p_addr <= bus.addr; p_wdata <= bus.wdata;
            end else begin
                pend <= 1'b0;
            end
        end
    end

    int nvec, nfail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pulses start for one cycle, then scrambles the inputs; cyc is the cycle index of done
    // where cycle 1 is the one following the start edge.
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            output int cyc, output int rds, output int wrs);
        int r0, w0;
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        r0 = rd_cnt; w0 = wr_cnt; wr_base = wr_cnt;
        @(negedge clk);
        src_i = s; dst_i = d; len_i = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; src_i = 32'hFFFF_FFFF; dst_i = 32'h0000_0005; len_i = 16'h0007;
        cyc = 1;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) cyc = -1;
        rds = rd_cnt - r0;
        wrs = wr_cnt - w0;
    endtask

    typedef struct {
        logic [31:0] s;
        logic [31:0] d;
        logic [15:0] l;
        int          ws;
        int          ew;
        logic        e;
        logic [31:0] code;
        int          rd;
        int          wr;
        int          cyc;
    } vec_t;

    vec_t vt [8];

    initial begin
        int cyc, rds, wrs, k;
        logic [7:0] si, di;
        nvec = 0; nfail = 0;
        ws = 0; err_wr = 0; wr_base = 0;
        rst = 1'b1; start = 1'b0; src_i = '0; dst_i = '0; len_i = '0;
`ifdef AXO_DMA_FILL_EN
        fill_i = 1'b0;
`endif
        vt[0] = '{32'h0000_0100, 32'h0000_0200, 16'd4, 0, 0, 1'b0, 32'h0,             4, 4, 9};
        vt[1] = '{32'h0000_0180, 32'h0000_0280, 16'd2, 3, 0, 1'b0, 32'h0,             2, 2, 17};
        vt[2] = '{32'h0000_0100, 32'h0000_0300, 16'd3, 0, 2, 1'b1, AXO_MEM_READONLY,  2, 1, 5};
        vt[3] = '{32'h0000_0102, 32'h0000_0380, 16'd1, 0, 0, 1'b1, AXO_DMA_EALIGN,    0, 0, 1};
        vt[4] = '{32'h0000_0100, 32'h0000_03C0, 16'd0, 0, 0, 1'b0, 32'h0,             0, 0, 1};
        vt[5] = '{32'h0000_0140, 32'h0000_0201, 16'd2, 0, 0, 1'b1, AXO_DMA_EALIGN,    0, 0, 1};
        vt[6] = '{32'hFFFF_FFFC, 32'h0000_03E0, 16'd2, 1, 0, 1'b0, 32'h0,             2, 2, 9};
        vt[7] = '{32'h0000_0010, 32'h0000_0020, 16'd2, 2, 1, 1'b1, AXO_MEM_READONLY,  1, 0, 7};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_err_code", err_code, 32'h0);
        check("rst_re_we", {30'b0, bus.re, bus.we}, 32'h0);
        check("rst_addr", bus.addr, 32'h0);
        check("rst_wdata", bus.wdata, 32'h0);
        check("rst_asize", {30'b0, bus.asize}, 32'h2);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            ws = vt[i].ws; err_wr = vt[i].ew;
            run_xfer(vt[i].s, vt[i].d, vt[i].l, cyc, rds, wrs);
            check($sformatf("v%0d_done_cycle", i), 32'(cyc), 32'(vt[i].cyc));
            check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vt[i].e});
            check($sformatf("v%0d_err_code", i), err_code, vt[i].code);
            check($sformatf("v%0d_reads", i), 32'(rds), 32'(vt[i].rd));
            check($sformatf("v%0d_writes", i), 32'(wrs), 32'(vt[i].wr));
            check($sformatf("v%0d_busy_at_done", i), {31'b0, busy}, 32'h0);
            if (!vt[i].e) begin
                for (int j = 0; j < int'(vt[i].l); j++) begin
                    si = vt[i].s[9:2] + 8'(j);
                    di = vt[i].d[9:2] + 8'(j);
                    check($sformatf("v%0d_word%0d", i, j), mem[di], snap[si]);
                end
            end
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'h0);
        end

        // start pulses while busy are ignored
        ws = 0; err_wr = 0;
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        rds = rd_cnt; wrs = wr_cnt; wr_base = wr_cnt;
        @(negedge clk);
        src_i = 32'h100; dst_i = 32'h200; len_i = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'h1);
        @(negedge clk);
        src_i = 32'h0; dst_i = 32'h3F0; len_i = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 2;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("busy_start_done_cycle", 32'(cyc), 32'd11);
        check("busy_start_reads", 32'(rd_cnt - rds), 32'd5);
        check("busy_start_writes", 32'(wr_cnt - wrs), 32'd5);
        check("busy_start_last_word", mem[132], snap[68]);
        check("busy_start_untouched", mem[252], snap[252]);

        // asynchronous reset while a write is stalled
        repeat (2) @(posedge clk);
        ws = 3; err_wr = 0;
        @(negedge clk);
        src_i = 32'h100; dst_i = 32'h340; len_i = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!bus.we && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_mid_reached_wr", {31'b0, bus.we}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_re_we", {30'b0, bus.re, bus.we}, 32'h0);
        check("rst_mid_busy_done", {30'b0, busy, done}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ws = 0; err_wr = 0;
        run_xfer(32'h100, 32'h3A0, 16'd1, cyc, rds, wrs);
        check("post_rst_done_cycle", 32'(cyc), 32'd3);
        check("post_rst_err", {31'b0, err}, 32'h0);
        check("post_rst_word", mem[232], 32'h1);

`ifdef AXO_DMA_FILL_EN
        @(posedge clk);
        fill_i = 1'b1;
        run_xfer(32'hDEAD_BEEF, 32'h40, 16'd3, cyc, rds, wrs);
        fill_i = 1'b0;
        check("fill_done_cycle", 32'(cyc), 32'd4);
        check("fill_reads", 32'(rds), 32'd0);
        check("fill_writes", 32'(wrs), 32'd3);
        check("fill_err", {31'b0, err}, 32'h0);
        for (int j = 16; j < 19; j++) check($sformatf("fill_word%0d", j), mem[j], 32'hDEAD_BEEF);
        check("fill_after", mem[19], snap[19]);
`endif

        @(posedge clk); #1;
        check("re_we_overlap", 32'(both_viol), 32'h0);
        check("stall_stability", 32'(stab_viol), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
